relu_maxpool_layer: RTL and testbench



---
 rtl/cnn_pkg.sv | 27 ++
 rtl/pool_idx_ctrl.sv | 46 ++++
 rtl/relu_maxpool_layer.sv | 96 +++++++++
 tb/tb_relu_maxpool_layer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared word type, range constants and helpers for the CNN datapath layers.
// The layers parameterise their own word width; word_t covers the default 16-bit build.
package cnn_pkg;

  localparam int WORD_SIZE = 16;

  typedef logic signed [WORD_SIZE-1:0] word_t;

  localparam word_t WORD_MIN = {1'b1, {(WORD_SIZE-1){1'b0}}};
  localparam word_t WORD_MAX = {1'b0, {(WORD_SIZE-1){1'b1}}};

  // Index width for a counter over n positions, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 32'sd1) ? $clog2(n) : 32'sd1;
  endfunction

  function automatic word_t relu(input word_t x, input logic en);
    word_t y;
    if (en && x[WORD_SIZE-1]) begin
      y = {WORD_SIZE{1'b0}};
    end else begin
      y = x;
    end
    return y;
  endfunction

endpackage

// File: rtl/pool_idx_ctrl.sv
// Channel/frame position tracker for the pooling stream: channel wraps every
// INPUT_SIZE accepts, frame advances on each channel wrap and wraps after POOL_SIZE.
module pool_idx_ctrl
  import cnn_pkg::idx_w;
#(
  parameter int INPUT_SIZE = 1,
  parameter int POOL_SIZE  = 2,
  localparam int CH_W      = idx_w(INPUT_SIZE),
  localparam int FR_W      = idx_w(POOL_SIZE)
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            en_i,
  output logic [CH_W-1:0] ch_o,
  output logic            first_o,
  output logic            last_o
);

  logic [CH_W-1:0] ch_r;
  logic [FR_W-1:0] fr_r;
  logic            ch_wrap_s;
  logic            fr_wrap_s;

  assign ch_wrap_s = (ch_r == CH_W'(INPUT_SIZE - 1));
  assign fr_wrap_s = (fr_r == FR_W'(POOL_SIZE - 1));

  // Advance channel, then frame on channel wrap.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ch_r <= {CH_W{1'b0}};
      fr_r <= {FR_W{1'b0}};
    end else if (en_i) begin
      if (ch_wrap_s) begin
        ch_r <= {CH_W{1'b0}};
        fr_r <= fr_wrap_s ? {FR_W{1'b0}} : fr_r + 1'b1;
      end else begin
        ch_r <= ch_r + 1'b1;
      end
    end
  end

  assign ch_o    = ch_r;
  assign first_o = (fr_r == {FR_W{1'b0}});
  assign last_o  = fr_wrap_s;

endmodule

// File: rtl/relu_maxpool_layer.sv
// ReLU followed by per-channel max-pooling over POOL_SIZE consecutive frames of a
// serial channel stream, with a registered valid/ready output word.
module relu_maxpool_layer
  import cnn_pkg::idx_w;
#(
  parameter int INPUT_SIZE = 1,
  parameter int POOL_SIZE  = 2,
  parameter int WORD_SIZE  = 16,
  parameter int RELU_EN    = 1
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  output logic                        ready_o,
  input  logic                        valid_i,
  input  logic signed [WORD_SIZE-1:0] data_r_i,
  output logic                        valid_o,
  input  logic                        ready_i,
  output logic signed [WORD_SIZE-1:0] data_r_o
);

  localparam int CH_W = idx_w(INPUT_SIZE);

  logic                        acc_s;
  logic                        snd_s;
  logic [CH_W-1:0]             ch_s;
  logic                        first_s;
  logic                        last_s;
  logic signed [WORD_SIZE-1:0] v_s;
  logic signed [WORD_SIZE-1:0] rd_s;
  logic signed [WORD_SIZE-1:0] m_s;
  logic signed [WORD_SIZE-1:0] buf_r [INPUT_SIZE];

  // Only a last-frame word can stall: it needs the output register free or draining.
  assign ready_o = ~(last_s & valid_o & ~ready_i);
  assign acc_s   = valid_i & ready_o;
  assign snd_s   = valid_o & ready_i;

  pool_idx_ctrl #(
    .INPUT_SIZE (INPUT_SIZE),
    .POOL_SIZE  (POOL_SIZE)
  ) u_idx (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .en_i    (acc_s),
    .ch_o    (ch_s),
    .first_o (first_s),
    .last_o  (last_s)
  );

  // Read the running maximum of the current channel.
  always_comb begin
    rd_s = buf_r[0];
    for (int i = 1; i < INPUT_SIZE; i++) begin
      rd_s = (ch_s == CH_W'(i)) ? buf_r[i] : rd_s;
    end
  end

  // ReLU then signed max against the stored value; frame 0 starts a fresh pool.
  always_comb begin
    if ((RELU_EN != 0) && data_r_i[WORD_SIZE-1]) begin
      v_s = {WORD_SIZE{1'b0}};
    end else begin
      v_s = data_r_i;
    end
    if (first_s) begin
      m_s = v_s;
    end else if (v_s > rd_s) begin
      m_s = v_s;
    end else begin
      m_s = rd_s;
    end
  end

  // Running-max buffer; no reset needed since frame 0 always overwrites it.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < INPUT_SIZE; i++) begin
      if (acc_s && !last_s && (ch_s == CH_W'(i))) begin
        buf_r[i] <= m_s;
      end
    end
  end

  // Output register: load on last-frame accept, clear valid on a plain send.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      valid_o  <= 1'b0;
      data_r_o <= {WORD_SIZE{1'b0}};
    end else if (acc_s && last_s) begin
      valid_o  <= 1'b1;
      data_r_o <= m_s;
    end else if (snd_s) begin
      valid_o  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_relu_maxpool_layer.sv
// Self-checking bench: directed scenarios plus randomized streams scored against
// a frame/channel max-of-ReLU reference computed from the accepted input words.
module tb_relu_maxpool_layer;

  typedef int q_t[$];

  logic clk;
  logic rst;

  // A: 3 channels, pool 2, ReLU on
  logic a_vi, a_ri, a_ro, a_vo;
  logic signed [15:0] a_di, a_do;
  // B: 1 channel, pool 3, ReLU off
  logic b_vi, b_ri, b_ro, b_vo;
  logic signed [15:0] b_di, b_do;
  // C: 2 channels, pool 1, ReLU on
  logic c_vi, c_ri, c_ro, c_vo;
  logic signed [15:0] c_di, c_do;

  q_t in_a, got_a, in_b, got_b, in_c, got_c;
  bit a_acc, b_acc;
  int n_tests = 0;
  int n_fail  = 0;

  relu_maxpool_layer #(.INPUT_SIZE(3), .POOL_SIZE(2), .WORD_SIZE(16), .RELU_EN(1)) u_a (
    .clk_i(clk), .reset_i(rst), .ready_o(a_ro), .valid_i(a_vi), .data_r_i(a_di),
    .valid_o(a_vo), .ready_i(a_ri), .data_r_o(a_do));

  relu_maxpool_layer #(.INPUT_SIZE(1), .POOL_SIZE(3), .WORD_SIZE(16), .RELU_EN(0)) u_b (
    .clk_i(clk), .reset_i(rst), .ready_o(b_ro), .valid_i(b_vi), .data_r_i(b_di),
    .valid_o(b_vo), .ready_i(b_ri), .data_r_o(b_do));

  relu_maxpool_layer #(.INPUT_SIZE(2), .POOL_SIZE(1), .WORD_SIZE(16), .RELU_EN(1)) u_c (
    .clk_i(clk), .reset_i(rst), .ready_o(c_ro), .valid_i(c_vi), .data_r_i(c_di),
    .valid_o(c_vo), .ready_i(c_ri), .data_r_o(c_do));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: each group of n*p accepted words yields n words, the max of relu() per channel.
  function automatic q_t pool_ref(input q_t src, input int n, input int p, input bit r);
    q_t res;
    for (int g = 0; (g + 1) * n * p <= src.size(); g++) begin
      for (int c = 0; c < n; c++) begin
        int best;
        for (int f = 0; f < p; f++) begin
          int x = src[g * n * p + f * n + c];
          if (r && x < 0) x = 0;
          if (f == 0 || x > best) best = x;
        end
        res.push_back(best);
      end
    end
    return res;
  endfunction

  task automatic cmp_stream(input string tag, input q_t got, input q_t exp);
    check_val({tag, "_count"}, got.size(), exp.size());
    for (int i = 0; i < got.size() && i < exp.size(); i++)
      check_val($sformatf("%s[%0d]", tag, i), got[i], exp[i]);
  endtask

  // Inputs are set just after a falling edge; observe handshakes 1 time unit later.
  task automatic cycle();
    #1;
    a_acc = a_vi && a_ro;
    b_acc = b_vi && b_ro;
    if (a_acc) in_a.push_back(int'(a_di));
    if (b_acc) in_b.push_back(int'(b_di));
    if (c_vi && c_ro) in_c.push_back(int'(c_di));
    if (a_vo && a_ri) got_a.push_back(int'(a_do));
    if (b_vo && b_ri) got_b.push_back(int'(b_do));
    if (c_vo && c_ri) got_c.push_back(int'(c_do));
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    a_vi = 1'b0; b_vi = 1'b0; c_vi = 1'b0;
    repeat (n) cycle();
  endtask

  task automatic clear_q();
    in_a.delete(); got_a.delete(); in_b.delete(); got_b.delete();
    in_c.delete(); got_c.delete();
  endtask

  task automatic send_a(input int w);
    int k = 0;
    a_vi = 1'b1; a_di = 16'(w);
    cycle();
    while (!a_acc && k < 50) begin cycle(); k++; end
    if (!a_acc) check_val("a_send_timeout", 0, 1);
    a_vi = 1'b0;
  endtask

  task automatic send_b(input int w);
    int k = 0;
    b_vi = 1'b1; b_di = 16'(w);
    cycle();
    while (!b_acc && k < 50) begin cycle(); k++; end
    if (!b_acc) check_val("b_send_timeout", 0, 1);
    b_vi = 1'b0;
  endtask

  initial begin
    int k;
    rst = 1'b1;
    a_vi = 1'b0; a_ri = 1'b1; a_di = 16'sd0;
    b_vi = 1'b0; b_ri = 1'b1; b_di = 16'sd0;
    c_vi = 1'b0; c_ri = 1'b1; c_di = 16'sd0;
    repeat (3) @(negedge clk);
    #1;
    check_val("rst_valid_a", a_vo, 0);
    check_val("rst_data_a", a_do, 0);
    check_val("rst_ready_a", a_ro, 1);
    check_val("rst_valid_b", b_vo, 0);
    check_val("rst_valid_c", c_vo, 0);
    @(negedge clk);
    rst = 1'b0;

    // Directed stream, output one cycle after each last-frame accept
    send_a(5); send_a(-4); send_a(7);
    send_a(2);
    #1;
    check_val("t1_lat_valid", a_vo, 1);
    check_val("t1_lat_data", a_do, 5);
    send_a(3); send_a(-1);
    idle(4);
    cmp_stream("t1_const", got_a, '{5, 3, 7});
    cmp_stream("t1_model", got_a, pool_ref(in_a, 3, 2, 1'b1));
    clear_q();

    // Backpressure during frame 1
    send_a(1); send_a(2); send_a(3);
    a_ri = 1'b0;
    send_a(4);
    a_vi = 1'b1; a_di = 16'sd5;
    #1;
    check_val("t2_ready_drop", a_ro, 0);
    check_val("t2_hold_valid", a_vo, 1);
    repeat (3) cycle();
    check_val("t2_hold_data", a_do, 4);
    check_val("t2_hold_valid2", a_vo, 1);
    a_ri = 1'b1;
    send_a(5); send_a(6);
    idle(4);
    cmp_stream("t2_const", got_a, '{4, 5, 6});
    clear_q();

    // ReLU clamps an all-negative pool to zero
    for (int i = 1; i <= 6; i++) send_a(-i);
    idle(4);
    cmp_stream("t3_relu", got_a, '{0, 0, 0});
    clear_q();

    // Pure max-pool of negatives, boundaries and ties
    send_b(-8); send_b(-3); send_b(-5);
    send_b(32767); send_b(-32768); send_b(-32768);
    send_b(100); send_b(100); send_b(100);
    send_b(-32768); send_b(-32768); send_b(-32768);
    idle(4);
    cmp_stream("t3_t6_b", got_b, '{-3, 32767, 100, -32768});
    clear_q();

    // Asynchronous reset mid-frame drops the pending output and partial pool
    send_a(10); send_a(20); send_a(30);
    send_a(1); send_a(2);
    #2;
    rst = 1'b1;
    #1;
    check_val("t5_rst_valid", a_vo, 0);
    check_val("t5_rst_data", a_do, 0);
    @(negedge clk);
    rst = 1'b0;
    clear_q();
    send_a(9); send_a(9); send_a(9);
    send_a(1); send_a(1); send_a(1);
    idle(4);
    cmp_stream("t5_after_rst", got_a, '{9, 9, 9});
    clear_q();

    // Randomized pass-through (pool 1)
    k = 0;
    while (in_c.size() < 1000 && k < 20000) begin
      c_vi = 1'($urandom_range(0, 1));
      c_di = 16'($urandom);
      c_ri = 1'($urandom_range(0, 1));
      cycle();
      k++;
    end
    c_ri = 1'b1;
    idle(6);
    check_val("t4_accepted", in_c.size(), 1000);
    cmp_stream("t4_rand", got_c, pool_ref(in_c, 2, 1, 1'b1));

    // Randomized pooling with backpressure
    k = 0;
    while (in_a.size() < 300 && k < 20000) begin
      a_vi = 1'($urandom_range(0, 1));
      a_di = 16'($urandom);
      a_ri = ($urandom_range(0, 3) != 0);
      cycle();
      k++;
    end
    a_ri = 1'b1;
    idle(6);
    check_val("rand_a_accepted", in_a.size(), 300);
    cmp_stream("rand_a", got_a, pool_ref(in_a, 3, 2, 1'b1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
